// File: rtl/protect_pkg.sv
// Shared encodings and region configuration type for the bus protection checker.
package protect_pkg;

    localparam int REGION_ADDR_WIDTH = 64;

    localparam logic [1:0] CFG_FIELD_BASE  = 2'd0;
    localparam logic [1:0] CFG_FIELD_LIMIT = 2'd1;
    localparam logic [1:0] CFG_FIELD_CTRL  = 2'd2;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_BLOCK_RD_BIT = 1;

    // Bounds are stored wide enough for any supported bus width, zero-extended.
    typedef struct packed {
        logic [REGION_ADDR_WIDTH-1:0] base;
        logic [REGION_ADDR_WIDTH-1:0] limit;
        logic                         enable;
        logic                         block_reads;
    } region_cfg_t;

endpackage

// File: rtl/protect_region_match.sv
// Combinational hit test of one request against one protected region.
module protect_region_match
    import protect_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  region_cfg_t          cfg,
    input  logic                 write,
    input  logic [BUS_WIDTH-1:0] addr,
    output logic                 match
);

    logic [REGION_ADDR_WIDTH-1:0] addr_ext;

    assign addr_ext = REGION_ADDR_WIDTH'(addr);

    // An inverted window (limit < base) can never satisfy both bounds.
    assign match = cfg.enable
                 && (addr_ext >= cfg.base)
                 && (addr_ext <= cfg.limit)
                 && (write || cfg.block_reads);

endmodule

// File: rtl/protect_monitor.sv
// Snoops bus requests against lockable protected regions and pulses viol_set
// two cycles after an offending request.
module protect_monitor
    import protect_pkg::*;
#(
    parameter int BUS_WIDTH        = 32,
    parameter int REGION_IDX_WIDTH = 2,
    parameter int COUNT_WIDTH      = 8
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        cfg_we,
    input  logic [REGION_IDX_WIDTH-1:0] cfg_idx,
    input  logic [1:0]                  cfg_field,
    input  logic [BUS_WIDTH-1:0]        cfg_wdata,
    input  logic                        cfg_lock,
    output logic                        cfg_locked,
    input  logic                        bus_valid,
    input  logic                        bus_write,
    input  logic [BUS_WIDTH-1:0]        bus_addr,
    output logic                        viol_set,
    output logic [BUS_WIDTH-1:0]        viol_addr,
    output logic [REGION_IDX_WIDTH-1:0] viol_region,
    output logic [COUNT_WIDTH-1:0]      viol_count
);

    localparam int REGION_NUM = 2 ** REGION_IDX_WIDTH;

    region_cfg_t                 cfg_q [REGION_NUM];
    logic                        s1_valid;
    logic                        s1_write;
    logic [BUS_WIDTH-1:0]        s1_addr;
    logic [REGION_NUM-1:0]       match;
    logic                        hit;
    logic [REGION_IDX_WIDTH-1:0] hit_idx;

    for (genvar g = 0; g < REGION_NUM; g++) begin : g_region
        protect_region_match #(
            .BUS_WIDTH(BUS_WIDTH)
        ) u_match (
            .cfg  (cfg_q[g]),
            .write(s1_write),
            .addr (s1_addr),
            .match(match[g])
        );
    end

    // Scan from the top so the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = REGION_NUM - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = REGION_IDX_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < REGION_NUM; i++) begin
                cfg_q[i] <= '0;
            end
            cfg_locked <= 1'b0;
        end else begin
            if (cfg_we && !cfg_locked && !cfg_lock) begin
                case (cfg_field)
                    CFG_FIELD_BASE:
                        cfg_q[cfg_idx].base <= REGION_ADDR_WIDTH'(cfg_wdata);
                    CFG_FIELD_LIMIT:
                        cfg_q[cfg_idx].limit <= REGION_ADDR_WIDTH'(cfg_wdata);
                    CFG_FIELD_CTRL: begin
                        cfg_q[cfg_idx].enable      <= cfg_wdata[CTRL_EN_BIT];
                        cfg_q[cfg_idx].block_reads <= cfg_wdata[CTRL_BLOCK_RD_BIT];
                    end
                    default: ;
                endcase
            end
            if (cfg_lock) begin
                cfg_locked <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            s1_valid    <= 1'b0;
            s1_write    <= 1'b0;
            s1_addr     <= '0;
            viol_set    <= 1'b0;
            viol_addr   <= '0;
            viol_region <= '0;
            viol_count  <= '0;
        end else begin
            s1_valid <= bus_valid;
            s1_write <= bus_write;
            s1_addr  <= bus_addr;
            viol_set <= s1_valid && hit;
            if (s1_valid && hit) begin
                viol_addr   <= s1_addr;
                viol_region <= hit_idx;
                if (viol_count != '1) begin
                    viol_count <= viol_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_protect_monitor.sv
// Directed plus randomized checks of protect_monitor against a region-list model.
module tb_protect_monitor;

    localparam int BW  = 32;
    localparam int IW  = 2;
    localparam int CW  = 2;
    localparam int NR  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          nreset;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [1:0]    cfg_field;
    logic [BW-1:0] cfg_wdata;
    logic          cfg_lock;
    logic          cfg_locked;
    logic          bus_valid;
    logic          bus_write;
    logic [BW-1:0] bus_addr;
    logic          viol_set;
    logic [BW-1:0] viol_addr;
    logic [IW-1:0] viol_region;
    logic [CW-1:0] viol_count;

    protect_monitor #(
        .BUS_WIDTH(BW),
        .REGION_IDX_WIDTH(IW),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_field  (cfg_field),
        .cfg_wdata  (cfg_wdata),
        .cfg_lock   (cfg_lock),
        .cfg_locked (cfg_locked),
        .bus_valid  (bus_valid),
        .bus_write  (bus_write),
        .bus_addr   (bus_addr),
        .viol_set   (viol_set),
        .viol_addr  (viol_addr),
        .viol_region(viol_region),
        .viol_count (viol_count)
    );

    always #5 clk = ~clk;

    // Model state: region list, lock flag, one pending request verdict.
    longint unsigned m_base [NR];
    longint unsigned m_limit[NR];
    bit              m_en   [NR];
    bit              m_br   [NR];
    bit              m_locked;
    bit              p_hit;
    int              p_reg;
    logic [BW-1:0]   p_addr;
    bit              e_set;
    logic [BW-1:0]   e_addr;
    int              e_reg;
    int              e_cnt;

    int checks = 0;
    int fails  = 0;

    function automatic int first_region(bit w, logic [BW-1:0] a);
        longint unsigned av = longint'(a);
        for (int i = 0; i < NR; i++) begin
            if (m_en[i] && m_base[i] <= av && av <= m_limit[i] && (w || m_br[i]))
                return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_base[i]  = 0;
            m_limit[i] = 0;
            m_en[i]    = 0;
            m_br[i]    = 0;
        end
        m_locked = 0;
        p_hit    = 0;
        p_reg    = 0;
        p_addr   = '0;
        e_set    = 0;
        e_addr   = '0;
        e_reg    = 0;
        e_cnt    = 0;
    endtask

    task automatic chk(string tag, longint obs, longint exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(bit rst, bit v, bit w, logic [BW-1:0] a,
                        bit we, int idx, int fld, logic [BW-1:0] wd, bit lk);
        int r;
        nreset    = !rst;
        bus_valid = v;
        bus_write = w;
        bus_addr  = a;
        cfg_we    = we;
        cfg_idx   = IW'(idx);
        cfg_field = 2'(fld);
        cfg_wdata = wd;
        cfg_lock  = lk;
        @(posedge clk);
        #1;
        if (rst) begin
            model_clear();
        end else begin
            e_set = p_hit;
            if (p_hit) begin
                e_addr = p_addr;
                e_reg  = p_reg;
                if (e_cnt < CMAX) e_cnt++;
            end
            if (we && !m_locked && !lk) begin
                case (fld)
                    0: m_base[idx]  = longint'(wd);
                    1: m_limit[idx] = longint'(wd);
                    2: begin
                        m_en[idx] = wd[0];
                        m_br[idx] = wd[1];
                    end
                    default: ;
                endcase
            end
            if (lk) m_locked = 1;
            r      = v ? first_region(w, a) : -1;
            p_hit  = (r >= 0);
            p_reg  = (r >= 0) ? r : 0;
            p_addr = a;
        end
        chk("viol_set", longint'(viol_set), longint'(e_set));
        chk("viol_addr", longint'(viol_addr), longint'(e_addr));
        chk("viol_region", longint'(viol_region), longint'(e_reg));
        chk("viol_count", longint'(viol_count), longint'(e_cnt));
        chk("cfg_locked", longint'(cfg_locked), longint'(m_locked));
    endtask

    task automatic cfgw(int idx, int fld, logic [BW-1:0] wd);
        step(0, 0, 0, '0, 1, idx, fld, wd, 0);
    endtask

    task automatic req(bit w, logic [BW-1:0] a);
        step(0, 1, w, a, 0, 0, 0, '0, 0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0, '0, 0);
    endtask

    task automatic rst_cycle();
        step(1, 0, 0, '0, 0, 0, 0, '0, 0);
    endtask

    initial begin
        model_clear();
        rst_cycle();
        rst_cycle();
        idle(1);

        cfgw(0, 0, 32'h1000);
        cfgw(0, 1, 32'h1FFF);
        cfgw(0, 2, 32'h1);
        req(1, 32'h1000);
        idle(2);
        req(1, 32'h2000);
        idle(2);
        req(0, 32'h1800);
        idle(2);

        cfgw(0, 2, 32'h3);
        req(0, 32'h1FFF);
        idle(2);
        cfgw(1, 0, 32'h10);
        cfgw(1, 1, 32'h0F);
        cfgw(1, 2, 32'h1);
        req(1, 32'h10);
        idle(2);

        cfgw(1, 0, 32'h4000);
        cfgw(1, 1, 32'h4FFF);
        cfgw(3, 0, 32'h3000);
        cfgw(3, 1, 32'h5000);
        cfgw(3, 2, 32'h1);
        req(1, 32'h4000);
        idle(2);

        rst_cycle();
        cfgw(0, 0, 32'h100);
        cfgw(0, 1, 32'h1FF);
        cfgw(0, 2, 32'h1);
        for (int i = 0; i < 5; i++) req(1, 32'h100 + 32'(i * 8));
        idle(2);

        req(1, 32'h180);
        rst_cycle();
        idle(2);
        req(1, 32'h180);
        idle(2);

        cfgw(2, 0, 32'h8000);
        cfgw(2, 1, 32'h8FFF);
        step(0, 0, 0, '0, 1, 2, 2, 32'h1, 1);
        cfgw(2, 2, 32'h1);
        cfgw(0, 2, 32'h0);
        req(1, 32'h8800);
        req(1, 32'h150);
        idle(2);

        rst_cycle();
        for (int i = 0; i < 500; i++) begin
            int sel = $urandom_range(0, 99);
            if (sel < 1) begin
                rst_cycle();
            end else if (sel < 2) begin
                step(0, 0, 0, '0, $urandom_range(0, 1), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom, 1);
            end else if (sel < 20) begin
                int fld = $urandom_range(0, 3);
                logic [BW-1:0] wd = (fld < 2) ? BW'($urandom_range(0, 255))
                                              : BW'($urandom);
                cfgw($urandom_range(0, 3), fld, wd);
            end else if (sel < 85) begin
                req($urandom_range(0, 1), BW'($urandom_range(0, 271)));
            end else begin
                idle(1);
            end
        end
        idle(3);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/protect_monitor.md
# protect_monitor

Bus-side protection checker that sits directly upstream of the protected-address flag latch. It snoops every memory request, compares it against a small set of programmable protected regions, and on a violation emits a one-cycle `viol_set` pulse with the offending address. These outputs drive the flag latch's `set` and `protected_addr_in` inputs. It also keeps a lockable region configuration and a saturating violation counter for diagnostics.

## Interface
- `BUS_WIDTH`, 32, address/data width.
- `REGION_IDX_WIDTH`, 2, region index width; `REGION_NUM = 2**REGION_IDX_WIDTH` regions.
- `COUNT_WIDTH`, 8, violation counter width.

- `clk`  in  1  single clock; all logic on posedge.
- `nreset`  in  1  synchronous, active-low reset.
- `cfg_we`  in  1  config write strobe.
- `cfg_idx`  in  REGION_IDX_WIDTH  target region.
- `cfg_field`  in  2  field select: 0 base, 1 limit, 2 ctrl, 3 reserved (write ignored).
- `cfg_wdata`  in  BUS_WIDTH  write data. For ctrl: bit0 enable, bit1 block_reads.
- `cfg_lock`  in  1  lock request; sticky until reset.
- `cfg_locked`  out  1  lock status.
- `bus_valid`  in  1  request valid this cycle.
- `bus_write`  in  1  1 = write, 0 = read.
- `bus_addr`  in  BUS_WIDTH  request address.
- `viol_set`  out  1  one-cycle violation pulse; feeds the flag latch `set`.
- `viol_addr`  out  BUS_WIDTH  violating address; valid while `viol_set` is high, held otherwise.
- `viol_region`  out  REGION_IDX_WIDTH  matching region index.
- `viol_count`  out  COUNT_WIDTH  saturating violation count.

## Operation
- Reset (`nreset` low at posedge):
  - All base, limit and ctrl registers clear to 0, so all regions are disabled.
  - `cfg_locked`, pipeline valids, `viol_set`, `viol_addr`, `viol_region` and `viol_count` all clear to 0.
  - In-flight requests are dropped and produce no pulse.
- Config write: on `cfg_we` && !`cfg_locked` && !`cfg_lock`, the selected field of region `cfg_idx` is updated. Lock wins over a write in the same cycle.
- Lock: `cfg_lock` high sets `cfg_locked` at the next edge. Once locked, all writes are ignored until reset.
- Region match: region i matches when all of the following hold:
  - enable_i = 1;
  - base_i <= addr <= limit_i, unsigned and inclusive at both ends;
  - the access is a write, or block_reads_i = 1.
- A region with limit < base never matches. Full-range coverage is base = 0, limit = all-ones; no overflow arithmetic is involved.
- Priority: if several regions match, the lowest index is reported.
- Pipeline:
  - Stage 1 (S1) registers `bus_valid`/`bus_write`/`bus_addr`.
  - Stage 2 (S2) compares the S1 contents against the config registers as they stand that cycle, and registers the result into `viol_*`.
- Counter: `viol_count` increments on each `viol_set` pulse and saturates at all-ones without wrapping.
- Back-to-back violating requests give consecutive high cycles on `viol_set`, each with its own `viol_addr`/`viol_region`. The downstream latch keeps the first address.

## Timing
- Request valid at edge N (sampled into S1) gives `viol_set` high during cycle N+2, i.e. latency 2. Throughput is 1 request per cycle; there is no backpressure.
- A config write at edge M affects compares whose S1 data is compared at edge M+1 or later. A request already in S1 at edge M uses the old config.
- `cfg_locked` rises one cycle after `cfg_lock`.
- `viol_count` updates on the same edge that `viol_set` goes high.
- Reset asserted mid-pipeline:
  - `viol_set` is 0 from the next edge.
  - No pulse is produced for requests in S1/S2 at reset.

## Structure
- Package `protect_pkg` holds:
  - `CFG_FIELD_BASE`/`LIMIT`/`CTRL` encodings;
  - ctrl bit positions `CTRL_EN_BIT`, `CTRL_BLOCK_RD_BIT`;
  - the region config struct typedef (base, limit, enable, block_reads).
- Sub-module `protect_region_match`: purely combinational compare for one region, giving a 1-bit match. It is instantiated `REGION_NUM` times via generate. The top level contains the config registers, lock, pipeline, priority encoder and counter.

## Test plan
- Reset, then write region 0 base=0x1000, limit=0x1FFF, ctrl=0x1. Then:
  - write to 0x1000 → `viol_set` pulse 2 cycles later, `viol_addr`=0x1000, `viol_region`=0, count=1;
  - write to 0x2000 → no pulse;
  - read to 0x1800 → no pulse.
- Set region 0 ctrl=0x3; read 0x1FFF → pulse. Region 1 base=0x10, limit=0x0F, enabled; access 0x10 → no pulse.
- Regions 1 and 3 both cover 0x4000; write 0x4000 → `viol_region`=1.
- Assert `cfg_lock` together with `cfg_we` (region 2 ctrl=0x1). Expect:
  - write ignored, `cfg_locked`=1 next cycle;
  - later writes ignored;
  - access to region 2 range → no pulse.
- With COUNT_WIDTH=2, issue 5 consecutive violating writes → `viol_set` high 5 consecutive cycles, `viol_count` stops at 3.
- Violating write at edge N, `nreset` low at edge N+1 → `viol_set` stays 0, all outputs 0, config cleared.
